// File: rtl/serial_bit_tx_pkg.sv
// Shared definitions for the single-bit serial transmitter: FSM state
// encodings and helpers for the length port width and the effective length.
package serial_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Bits needed to hold any length from 0 up to and including width.
  function automatic int len_width(input int width);
    return $clog2(width + 32'sd1);
  endfunction

  // A length of zero or one beyond the word size means "send the full word".
  function automatic int eff_len(input int len_v, input int width);
    if ((len_v == 32'sd0) || (len_v > width)) begin
      return width;
    end else begin
      return len_v;
    end
  endfunction

endpackage

// File: rtl/serial_bit_tx_piso_shreg.sv
// Parallel-in serial-out shift register. The serial tap is always the end
// bit of the register: bit 0 for LSB-first, bit WIDTH-1 for MSB-first. For
// MSB-first the word is loaded left-aligned so that bit len-1 sits on the
// tap. next_bit shows the tap value the register will hold after this edge,
// so the parent can register it as the outgoing bit.
module piso_shreg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         shift,
  input  logic [WIDTH-1:0]             data,
  input  logic [$clog2(WIDTH+1)-1:0]   len_eff,
  output logic                         next_bit
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] aligned_s;
  logic [WIDTH-1:0] next_q_s;

  // Align the incoming word so the first bit to send lands on the tap.
  always_comb begin
    aligned_s = data;
    if (LSB_FIRST) begin
      aligned_s = data;
    end else begin
      aligned_s = data << (WIDTH - int'(len_eff));
    end
  end

  // Next register contents: load, shift toward the tap, or hold.
  always_comb begin
    next_q_s = q_r;
    if (load) begin
      next_q_s = aligned_s;
    end else if (shift) begin
      if (LSB_FIRST) begin
        next_q_s = {1'b0, q_r[WIDTH-1:1]};
      end else begin
        next_q_s = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      next_q_s = q_r;
    end
  end

  assign next_bit = LSB_FIRST ? next_q_s[0] : next_q_s[WIDTH-1];

  // Shift register state, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else begin
      q_r <= next_q_s;
    end
  end

endmodule

// File: rtl/serial_bit_tx.sv
// Serial bit transmitter: accepts a word on a ready/start handshake and
// emits it one bit per clock on W with a valid qualifier, followed by a
// single-cycle done pulse. All outputs come straight from flops.
module serial_bit_tx import serial_tx_pkg::*; #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(WIDTH+1)-1:0] len,
  output logic                       ready,
  output logic                       W,
  output logic                       valid,
  output logic                       done
);

  localparam int LW = len_width(WIDTH);

  logic [1:0]    state_r;
  logic          ready_r;
  logic          w_r;
  logic          valid_r;
  logic          done_r;
  logic [LW-1:0] cnt_r;
  logic [LW-1:0] len_r;
  logic [LW-1:0] len_eff_s;
  logic          load_s;
  logic          shift_s;
  logic          next_bit_s;

  assign len_eff_s = LW'(eff_len(int'(len), WIDTH));

  // Decide when the shift register loads a new word or advances one bit.
  always_comb begin
    load_s  = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      ST_IDLE:  load_s  = start;
      ST_SHIFT: shift_s = (cnt_r != len_r);
      default: begin
        load_s  = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .shift    (shift_s),
    .data     (data),
    .len_eff  (len_eff_s),
    .next_bit (next_bit_s)
  );

  // Control FSM, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      w_r     <= IDLE_LEVEL;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      cnt_r   <= '0;
      len_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            // First bit appears on W one cycle after acceptance.
            state_r <= ST_SHIFT;
            ready_r <= 1'b0;
            w_r     <= next_bit_s;
            valid_r <= 1'b1;
            done_r  <= 1'b0;
            cnt_r   <= LW'(1);
            len_r   <= len_eff_s;
          end else begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            w_r     <= IDLE_LEVEL;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_r == len_r) begin
            // Last bit has been held for a full cycle.
            state_r <= ST_DONE;
            ready_r <= 1'b0;
            w_r     <= IDLE_LEVEL;
            valid_r <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
            ready_r <= 1'b0;
            w_r     <= next_bit_s;
            valid_r <= 1'b1;
            done_r  <= 1'b0;
            cnt_r   <= cnt_r + LW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          w_r     <= IDLE_LEVEL;
          valid_r <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= '0;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle.
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
          w_r     <= IDLE_LEVEL;
          valid_r <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign W     = w_r;
  assign valid = valid_r;
  assign done  = done_r;

endmodule
